// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among NUM_PORTS requesters, one access at a time, round-robin.
// Define SDRAM_ARB_FIXED_PRIO_EN to give port 0 absolute priority over the round-robin ports.
module sdram_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                          sdram_clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          req_ren,
  input  logic [NUM_PORTS-1:0]          req_wen,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
  output logic [NUM_PORTS-1:0]          req_done,
  output logic [DATA_W-1:0]             req_rdata,
  output logic                          sdram_ren,
  output logic                          sdram_wen,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_data_out,
  output logic [DATA_W/8-1:0]           sdram_byte_select_vector,
  input  logic [DATA_W-1:0]             sdram_data_in,
  input  logic                          ram_ack,
  output logic [1:0]                    dbg_state
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(NUM_PORTS);

  // Handshake: a requester holds ren/wen with stable addr/wdata/be until its one-cycle
  // req_done pulse; the controller answers a strobe with ram_ack, which also drops the strobe.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_AWAIT_ACK = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              state;
  logic [PW-1:0]       last_grant;
  logic [PW-1:0]       winner;
  logic [PW-1:0]       next_winner;
  logic                op_read;
  logic                ren_r;
  logic                wen_r;
  logic [NUM_PORTS-1:0] req_any;
  int                  idx;

  assign req_any = req_ren | req_wen;

  // Scanning from the farthest candidate back to the nearest lets the closest
  // requester after last_grant overwrite all others.
  always_comb begin
    next_winner = '0;
    idx         = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req_any[idx]) next_winner = PW'(idx);
    end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    if (req_any[0]) next_winner = '0;
`endif
  end

  always_ff @(posedge sdram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state                    <= S_IDLE;
      last_grant               <= PW'(NUM_PORTS - 1);
      winner                   <= '0;
      op_read                  <= 1'b0;
      ren_r                    <= 1'b0;
      wen_r                    <= 1'b0;
      req_done                 <= '0;
      req_rdata                <= '0;
      sdram_addr               <= '0;
      sdram_data_out           <= '0;
      sdram_byte_select_vector <= '0;
    end else begin
      req_done <= '0;
      case (state)
        S_IDLE: begin
          if (|req_any) begin
            winner         <= next_winner;
            last_grant     <= next_winner;
            op_read        <= req_ren[next_winner];
            sdram_addr     <= req_addr[next_winner*ADDR_W +: ADDR_W];
            sdram_data_out <= req_wdata[next_winner*DATA_W +: DATA_W];
            // Reads enable every byte lane; writes invert the active-high enables.
            if (req_ren[next_winner])
              sdram_byte_select_vector <= '0;
            else
              sdram_byte_select_vector <= ~req_be[next_winner*BE_W +: BE_W];
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          ren_r <= op_read;
          wen_r <= ~op_read;
          state <= S_AWAIT_ACK;
        end
        S_AWAIT_ACK: begin
          if (ram_ack) begin
            ren_r <= 1'b0;
            wen_r <= 1'b0;
            if (op_read) req_rdata <= sdram_data_in;
            req_done[winner] <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The ack cycle already masks the strobe so the controller never sees a second request.
  assign sdram_ren = ren_r & ~ram_ack;
  assign sdram_wen = wen_r & ~ram_ack;
  assign dbg_state = state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized traffic
// against an in-bench round-robin reference model.
module tb_sdram_port_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic              sdram_clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     req_ren, req_wen, req_done;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*BW-1:0]  req_be;
  logic [DW-1:0]     req_rdata, sdram_data_out, sdram_data_in;
  logic              sdram_ren, sdram_wen, ram_ack;
  logic [AW-1:0]     sdram_addr;
  logic [BW-1:0]     sdram_byte_select_vector;
  logic [1:0]        dbg_state;

  sdram_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .sdram_clk(sdram_clk), .reset_n(reset_n),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_done(req_done),
    .req_rdata(req_rdata), .sdram_ren(sdram_ren), .sdram_wen(sdram_wen),
    .sdram_addr(sdram_addr), .sdram_data_out(sdram_data_out),
    .sdram_byte_select_vector(sdram_byte_select_vector),
    .sdram_data_in(sdram_data_in), .ram_ack(ram_ack), .dbg_state(dbg_state)
  );

  // Clock
  always #5 sdram_clk = ~sdram_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Requester model state
  logic [NP-1:0] m_ren, m_wen, m_act;
  logic [AW-1:0] m_addr  [NP];
  logic [DW-1:0] m_wdata [NP];
  logic [BW-1:0] m_be    [NP];
  logic [DW-1:0] exp_rdata;
  logic [1:0]    exp_q[$];

  // Controller responder state
  logic          resp_en   = 1'b0;
  logic          resp_rand = 1'b0;
  logic          man_ack   = 1'b0;
  int            resp_delay = 0;
  int            resp_cnt   = 0;
  int            ack_cnt    = 0;
  logic [DW-1:0] resp_data  = '0;
  logic          ack_ren, ack_wen;
  logic [AW-1:0] ack_addr;
  logic [DW-1:0] ack_wdata, ack_data;
  logic [BW-1:0] ack_bsv;

  // Controller model: acks a strobe after it has been visible for resp_delay cycles.
  initial begin
    ram_ack       = 1'b0;
    sdram_data_in = '0;
    forever begin
      @(posedge sdram_clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        ram_ack  = 1'b0;
        resp_cnt = 0;
      end else if (!resp_en) begin
        ram_ack       = man_ack;
        sdram_data_in = resp_data;
      end else if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (sdram_ren || sdram_wen) begin
        if (resp_cnt >= resp_delay) begin
          ack_ren       = sdram_ren;
          ack_wen       = sdram_wen;
          ack_addr      = sdram_addr;
          ack_wdata     = sdram_data_out;
          ack_bsv       = sdram_byte_select_vector;
          sdram_data_in = resp_rand ? $urandom : resp_data;
          ack_data      = sdram_data_in;
          ram_ack       = 1'b1;
          resp_cnt      = 0;
          ack_cnt++;
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  // Reference arbitration: first requester after last, wrapping (port 0 first if fixed priority).
  function automatic int pick(input logic [NP-1:0] act, input int last);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    if (act[0]) return 0;
`endif
    for (int k = 1; k <= NP; k++) begin
      if (act[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic drive_reqs;
    for (int i = 0; i < NP; i++) begin
      req_ren[i]             = m_ren[i];
      req_wen[i]             = m_wen[i];
      req_addr[i*AW +: AW]   = m_addr[i];
      req_wdata[i*DW +: DW]  = m_wdata[i];
      req_be[i*BW +: BW]     = m_be[i];
    end
  endtask

  task automatic clear_reqs;
    m_ren = '0;
    m_wen = '0;
    m_act = '0;
    for (int i = 0; i < NP; i++) begin
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_be[i]    = '0;
    end
    drive_reqs();
  endtask

  task automatic pulse_reset;
    @(negedge sdram_clk);
    reset_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge sdram_clk);
    reset_n   = 1'b1;
    exp_rdata = '0;
    @(negedge sdram_clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    clear_reqs();
    repeat (3) @(negedge sdram_clk);
    tests_run++;
    if ({sdram_ren, sdram_wen, req_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_strobes_done got=%0b exp=0", {sdram_ren, sdram_wen, req_done});
    end
    tests_run++;
    if (req_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_rdata got=%0h exp=0", req_rdata);
    end
    tests_run++;
    if ({sdram_addr, sdram_data_out, sdram_byte_select_vector} !== '0) begin
      tests_failed++;
      $display("FAIL reset_sdram_outs got=%0h/%0h/%0h exp=0", sdram_addr, sdram_data_out,
               sdram_byte_select_vector);
    end
    reset_n   = 1'b1;
    exp_rdata = '0;
    repeat (2) @(negedge sdram_clk);
    tests_run++;
    if ({sdram_ren, sdram_wen, req_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_release_idle got=%0b exp=0", {sdram_ren, sdram_wen, req_done});
    end
  endtask

  task automatic test_read;
    int ren_cycles = 0;
    logic wen_seen = 1'b0, done_seen = 1'b0;
    logic [NP-1:0] done_val = '0;
    resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 3; resp_data = 32'hDEADBEEF;
    m_ren[0] = 1'b1; m_addr[0] = 32'h100; m_wdata[0] = 32'h0BAD0BAD; m_be[0] = 4'hF;
    drive_reqs();
    for (int c = 0; c < 30 && !done_seen; c++) begin
      @(negedge sdram_clk);
      if (sdram_ren) ren_cycles++;
      if (sdram_wen) wen_seen = 1'b1;
      if (req_done !== '0) begin done_seen = 1'b1; done_val = req_done; end
    end
    m_ren[0] = 1'b0;
    drive_reqs();
    exp_rdata = 32'hDEADBEEF;
    tests_run++;
    if (done_val !== 3'b001) begin
      tests_failed++;
      $display("FAIL read_done got=%0b exp=001", done_val);
    end
    tests_run++;
    if (ren_cycles != 3 || wen_seen) begin
      tests_failed++;
      $display("FAIL read_strobe ren_cycles=%0d wen_seen=%0b exp 3/0", ren_cycles, wen_seen);
    end
    tests_run++;
    if (req_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL read_rdata got=%0h exp=deadbeef", req_rdata);
    end
    tests_run++;
    if (ack_addr !== 32'h100 || ack_bsv !== 4'h0) begin
      tests_failed++;
      $display("FAIL read_addr_mask got=%0h/%0h exp=100/0", ack_addr, ack_bsv);
    end
    @(negedge sdram_clk);
    tests_run++;
    if (req_done !== '0) begin
      tests_failed++;
      $display("FAIL read_done_width got=%0b exp=0", req_done);
    end
  endtask

  task automatic test_write;
    int wen_cycles = 0;
    logic ren_seen = 1'b0, done_seen = 1'b0;
    logic [NP-1:0] done_val = '0;
    resp_delay = 2;
    m_wen[1] = 1'b1; m_addr[1] = 32'h200; m_wdata[1] = 32'h55AA1234; m_be[1] = 4'b0011;
    drive_reqs();
    for (int c = 0; c < 30 && !done_seen; c++) begin
      @(negedge sdram_clk);
      if (sdram_wen) wen_cycles++;
      if (sdram_ren) ren_seen = 1'b1;
      if (req_done !== '0) begin done_seen = 1'b1; done_val = req_done; end
    end
    m_wen[1] = 1'b0;
    drive_reqs();
    tests_run++;
    if (done_val !== 3'b010) begin
      tests_failed++;
      $display("FAIL write_done got=%0b exp=010", done_val);
    end
    tests_run++;
    if (wen_cycles != 2 || ren_seen) begin
      tests_failed++;
      $display("FAIL write_strobe wen_cycles=%0d ren_seen=%0b exp 2/0", wen_cycles, ren_seen);
    end
    tests_run++;
    if (ack_bsv !== 4'b1100 || ack_wdata !== 32'h55AA1234 || ack_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL write_bus got bsv=%0b data=%0h addr=%0h exp 1100/55aa1234/200",
               ack_bsv, ack_wdata, ack_addr);
    end
    tests_run++;
    if (req_rdata !== exp_rdata) begin
      tests_failed++;
      $display("FAIL write_keeps_rdata got=%0h exp=%0h", req_rdata, exp_rdata);
    end
  endtask

  task automatic test_round_robin;
    int last = NP - 1;
    int n = 0;
    logic [1:0] e;
    pulse_reset();
    resp_en = 1'b1; resp_delay = 0;
    exp_q.delete();
    for (int g = 0; g < 6; g++) begin
      last = pick('1, last);
      exp_q.push_back(2'(last));
    end
    for (int i = 0; i < NP; i++) begin
      m_ren[i] = 1'b1;
      m_addr[i] = 32'h1000 + AW'(i);
    end
    drive_reqs();
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge sdram_clk);
      if (req_done !== '0) begin
        e = exp_q.pop_front();
        n++;
        tests_run++;
        if (req_done !== (3'b001 << e)) begin
          tests_failed++;
          $display("FAIL rr_grant_%0d got=%0b exp_port=%0d", n, req_done, e);
        end
        if (n == 6) clear_reqs();
      end
    end
    tests_run++;
    if (n != 6) begin
      tests_failed++;
      $display("FAIL rr_timeout grants=%0d exp=6", n);
    end
    repeat (3) @(negedge sdram_clk);
  endtask

  task automatic test_reset_mid;
    logic done_seen = 1'b0;
    logic [NP-1:0] done_val = '0;
    int first;
    pulse_reset();
    resp_en = 1'b1; resp_delay = 0;
    m_ren[0] = 1'b1; m_addr[0] = 32'h40;
    drive_reqs();
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge sdram_clk);
      if (req_done !== '0) done_seen = 1'b1;
    end
    m_ren[0] = 1'b0;
    drive_reqs();
    @(negedge sdram_clk);
    resp_en = 1'b0; man_ack = 1'b0;
    m_wen[0] = 1'b1; m_addr[0] = 32'hA0; m_wdata[0] = 32'h1; m_be[0] = 4'hF;
    m_wen[1] = 1'b1; m_addr[1] = 32'hB0; m_wdata[1] = 32'h2; m_be[1] = 4'hF;
    drive_reqs();
    first = pick(3'b011, 0);
    repeat (3) @(negedge sdram_clk);
    tests_run++;
    if (sdram_wen !== 1'b1 || sdram_addr !== m_addr[first]) begin
      tests_failed++;
      $display("FAIL rst_mid_pre got wen=%0b addr=%0h exp 1/%0h", sdram_wen, sdram_addr, m_addr[first]);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({sdram_ren, sdram_wen, req_done} !== '0 || sdram_addr !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async got=%0b addr=%0h exp=0", {sdram_ren, sdram_wen, req_done}, sdram_addr);
    end
    repeat (2) @(negedge sdram_clk);
    reset_n = 1'b1;
    exp_rdata = '0;
    resp_en = 1'b1; resp_delay = 1;
    for (int p = 0; p < 2; p++) begin
      done_seen = 1'b0; done_val = '0;
      for (int c = 0; c < 20 && !done_seen; c++) begin
        @(negedge sdram_clk);
        if (req_done !== '0) begin done_seen = 1'b1; done_val = req_done; end
      end
      m_wen[p] = 1'b0;
      drive_reqs();
      tests_run++;
      if (done_val !== (3'b001 << p) || ack_addr !== m_addr[p]) begin
        tests_failed++;
        $display("FAIL rst_mid_regrant_%0d got done=%0b addr=%0h exp port %0d", p, done_val, ack_addr, p);
      end
    end
    @(negedge sdram_clk);
  endtask

  task automatic test_drop_and_spurious;
    logic bad = 1'b0;
    resp_en = 1'b0; man_ack = 1'b0; resp_data = 32'hCAFEF00D;
    @(negedge sdram_clk);
    man_ack = 1'b1;
    @(negedge sdram_clk);
    man_ack = 1'b0;
    repeat (3) begin
      @(negedge sdram_clk);
      if ({sdram_ren, sdram_wen, req_done} !== '0) bad = 1'b1;
    end
    tests_run++;
    if (bad || req_rdata !== exp_rdata) begin
      tests_failed++;
      $display("FAIL spurious_ack activity=%0b rdata=%0h exp 0/%0h", bad, req_rdata, exp_rdata);
    end
    m_ren[0] = 1'b1; m_addr[0] = 32'h300;
    drive_reqs();
    @(negedge sdram_clk);
    m_ren[0] = 1'b0;
    drive_reqs();
    repeat (3) @(negedge sdram_clk);
    tests_run++;
    if (sdram_ren !== 1'b1 || sdram_addr !== 32'h300) begin
      tests_failed++;
      $display("FAIL drop_still_pending got ren=%0b addr=%0h exp 1/300", sdram_ren, sdram_addr);
    end
    resp_data = 32'h12345678;
    man_ack = 1'b1;
    @(negedge sdram_clk);
    man_ack = 1'b0;
    tests_run++;
    if (sdram_ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_ack_masks got=%0b exp=0", sdram_ren);
    end
    @(negedge sdram_clk);
    exp_rdata = 32'h12345678;
    tests_run++;
    if (req_done !== 3'b001 || req_rdata !== exp_rdata) begin
      tests_failed++;
      $display("FAIL drop_completes got done=%0b rdata=%0h exp 001/%0h", req_done, req_rdata, exp_rdata);
    end
    @(negedge sdram_clk);
    tests_run++;
    if (req_done !== '0) begin
      tests_failed++;
      $display("FAIL drop_done_width got=%0b exp=0", req_done);
    end
  endtask

  task automatic new_req(input int i);
    int op = $urandom_range(0, 2);
    m_ren[i]   = (op != 1);
    m_wen[i]   = (op != 0);
    m_act[i]   = 1'b1;
    m_addr[i]  = $urandom;
    m_wdata[i] = $urandom;
    m_be[i]    = BW'($urandom_range(0, 15));
  endtask

  task automatic test_random;
    int last = NP - 1;
    int exp_p;
    int n_done = 0;
    logic prev_done = 1'b0;
    logic rd;
    logic [NP-1:0] exp_oh;
    pulse_reset();
    resp_en = 1'b1; resp_rand = 1'b1; resp_delay = $urandom_range(0, 3);
    ack_cnt = 0;
    for (int i = 0; i < NP; i++) if ($urandom_range(0, 1) == 1) new_req(i);
    if (m_act == '0) new_req($urandom_range(0, NP - 1));
    drive_reqs();
    exp_p = pick(m_act, last);
    for (int c = 0; c < 3000 && n_done < 40; c++) begin
      @(negedge sdram_clk);
      tests_run++;
      if ((sdram_ren && sdram_wen) || (prev_done && req_done !== '0)) begin
        tests_failed++;
        $display("FAIL rand_exclusive ren=%0b wen=%0b done=%0b", sdram_ren, sdram_wen, req_done);
      end
      prev_done = (req_done !== '0);
      if (req_done !== '0) begin
        exp_oh = '0;
        exp_oh[exp_p] = 1'b1;
        rd = m_ren[exp_p];
        if (rd) exp_rdata = ack_data;
        tests_run++;
        if (req_done !== exp_oh || ack_cnt != 1) begin
          tests_failed++;
          $display("FAIL rand_grant got=%0b exp=%0b acks=%0d", req_done, exp_oh, ack_cnt);
        end
        tests_run++;
        if (ack_ren !== rd || ack_wen !== !rd || ack_addr !== m_addr[exp_p]) begin
          tests_failed++;
          $display("FAIL rand_op got r=%0b w=%0b addr=%0h exp r=%0b addr=%0h",
                   ack_ren, ack_wen, ack_addr, rd, m_addr[exp_p]);
        end
        tests_run++;
        if (rd ? (ack_bsv !== '0) : (ack_bsv !== ~m_be[exp_p] || ack_wdata !== m_wdata[exp_p])) begin
          tests_failed++;
          $display("FAIL rand_data got bsv=%0h wdata=%0h exp be=%0h wdata=%0h read=%0b",
                   ack_bsv, ack_wdata, m_be[exp_p], m_wdata[exp_p], rd);
        end
        tests_run++;
        if (req_rdata !== exp_rdata) begin
          tests_failed++;
          $display("FAIL rand_rdata got=%0h exp=%0h", req_rdata, exp_rdata);
        end
        ack_cnt = 0;
        n_done++;
        last = exp_p;
        m_act[exp_p] = 1'b0; m_ren[exp_p] = 1'b0; m_wen[exp_p] = 1'b0;
        if (n_done < 40) begin
          for (int i = 0; i < NP; i++) if (!m_act[i] && $urandom_range(0, 1) == 1) new_req(i);
          if (m_act == '0) new_req($urandom_range(0, NP - 1));
          resp_delay = $urandom_range(0, 3);
          exp_p = pick(m_act, last);
        end else begin
          clear_reqs();
        end
        drive_reqs();
      end
    end
    tests_run++;
    if (n_done != 40) begin
      tests_failed++;
      $display("FAIL rand_timeout completed=%0d exp=40", n_done);
    end
    repeat (3) @(negedge sdram_clk);
  endtask

  initial begin
    reset_n = 1'b0;
    exp_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_reset_mid();
    test_drop_and_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have port sdram_clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_ren  input  NUM_PORTS  per-port read request, held until done.
REQ-007 SHALL have port req_wen  input  NUM_PORTS  per-port write request, held until done.
REQ-008 SHALL have port req_addr  input  NUM_PORTS*ADDR_W  per-port address, port i at slice i.
REQ-009 SHALL have port req_wdata  input  NUM_PORTS*DATA_W  per-port write data.
REQ-010 SHALL have port req_be  input  NUM_PORTS*DATA_W/8  per-port byte enables, active-high.
REQ-011 SHALL have port req_done  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-012 SHALL have port req_rdata  output  DATA_W  read data, shared by all ports.
REQ-013 SHALL have port sdram_ren / sdram_wen  output  1 each  controller read/write strobe.
REQ-014 SHALL have port sdram_addr  output  ADDR_W; sdram_data_out  output  DATA_W; sdram_byte_select_vector  output  DATA_W/8, active-low mask.
REQ-015 SHALL have port sdram_data_in  input  DATA_W; ram_ack  input  1  controller completion.

Function
REQ-016 SHALL implement FSM IDLE -> GRANT -> AWAIT_ACK -> DONE -> IDLE.
REQ-017 IDLE: if any port has ren|wen, SHALL select winner, latch its addr, wdata, ~be (writes) or all-zero mask (reads), and op type; go to GRANT.
REQ-018 GRANT: SHALL set the registered strobe for the latched op; go to AWAIT_ACK.
REQ-019 AWAIT_ACK: sdram_ren/sdram_wen SHALL equal registered strobe AND NOT ram_ack; on ram_ack clear strobe, capture sdram_data_in into req_rdata if read, go to DONE.
REQ-020 DONE: SHALL pulse req_done[winner] for exactly one cycle; go to IDLE.
REQ-021 Latency: request sampled at edge 0 -> strobe high after edge 1 -> done high the cycle after the ram_ack edge; minimum 4 cycles request-to-done.
REQ-022 Round-robin: search SHALL start at (last_grant+1) mod NUM_PORTS, wrapping; last_grant updates on each grant.
REQ-023 Same port with ren and wen both high SHALL be serviced as a read.
REQ-024 req_rdata SHALL hold its value until the next read completes; writes SHALL not alter it.
REQ-025 Requests deasserted after grant SHALL not abort; access completes and done still pulses.
REQ-026 New requests arriving outside IDLE SHALL wait; no request SHALL be lost while held.
REQ-027 ram_ack outside AWAIT_ACK SHALL be ignored.
REQ-028 Only one access SHALL be outstanding at any time.

Reset
REQ-029 On reset_n low, immediately and mid-access: state IDLE, strobes 0, req_done 0, req_rdata 0, sdram_addr 0, sdram_data_out 0, sdram_byte_select_vector 0, last_grant NUM_PORTS-1 (port 0 wins first).

Configuration
REQ-030 With macro SDRAM_ARB_FIXED_PRIO_EN defined, port 0 SHALL always win when requesting, remaining ports round-robin; undefined: pure round-robin per REQ-022.

Verification
REQ-031 Port0 read addr 0x100, ack after 3 cycles with data 0xDEADBEEF -> sdram_ren high until ack, req_done[0] one pulse, req_rdata 0xDEADBEEF.
REQ-032 Port1 write 0x55AA1234, be 4'b0011 -> sdram_wen high, sdram_byte_select_vector 4'b1100, sdram_data_out 0x55AA1234, req_done[1] pulse.
REQ-033 NUM_PORTS=3, all ports request continuously -> grant order 0,1,2,0,1,2; with SDRAM_ARB_FIXED_PRIO_EN -> port 0 every grant.
REQ-034 reset_n low during AWAIT_ACK -> strobes 0 at once, no done pulse; after release, still-held request re-granted from port 0.
REQ-035 Port0 drops ren in GRANT; spurious ram_ack while IDLE -> access completes with done pulse; spurious ack causes no state change.
